// File: rtl/grf_multiport.sv
// Multi-port general register file with same-cycle write-to-read bypass
// and a per-register busy scoreboard for the hazard unit.
module grf_multiport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   read_number,
    output logic [NUM_READ*DATA_WIDTH-1:0]   read_data,
    output logic [NUM_READ-1:0]              read_busy,
    input  logic [NUM_WRITE-1:0]             write_enable,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  write_number,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]  write_data,
    input  logic                             reserve_enable,
    input  logic [ADDR_WIDTH-1:0]            reserve_number,
    output logic [2**ADDR_WIDTH-1:0]         busy_vector
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs   [DEPTH];
    logic [DATA_WIDTH-1:0] wr_val [DEPTH];
    logic [DEPTH-1:0]      wr_hit;
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_next;

    // Per-register write decode; scanning ports upward lets the highest index win.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wr_hit[i] = 1'b0;
            wr_val[i] = '0;
            for (int p = 0; p < NUM_WRITE; p++) begin
                if (write_enable[p] &&
                    write_number[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(i)) begin
                    wr_hit[i] = 1'b1;
                    wr_val[i] = write_data[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (ZERO_REG != 0 && i == 0) begin
                wr_hit[i] = 1'b0;
                wr_val[i] = '0;
            end
        end
    end

    // A reserve names a new producer, so it overrides a same-cycle completing write.
    always_comb begin
        busy_next = busy;
        for (int i = 0; i < DEPTH; i++) begin
            if (reserve_enable && reserve_number == ADDR_WIDTH'(i)) begin
                busy_next[i] = 1'b1;
            end else if (wr_hit[i]) begin
                busy_next[i] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_hit[i]) begin
                    regs[i] <= wr_val[i];
                end
            end
            busy <= busy_next;
        end
    end

    assign busy_vector = busy;

    for (genvar r = 0; r < NUM_READ; r++) begin : g_read
        logic [ADDR_WIDTH-1:0] rd_idx;
        assign rd_idx = read_number[r*ADDR_WIDTH +: ADDR_WIDTH];

        // A bypassed value is current, so its register is not reported busy.
        always_comb begin
            if (ZERO_REG != 0 && rd_idx == '0) begin
                read_data[r*DATA_WIDTH +: DATA_WIDTH] = '0;
                read_busy[r]                          = 1'b0;
            end else begin
                read_data[r*DATA_WIDTH +: DATA_WIDTH] =
                    wr_hit[rd_idx] ? wr_val[rd_idx] : regs[rd_idx];
                read_busy[r] = busy[rd_idx] & ~wr_hit[rd_idx];
            end
        end
    end

`ifdef DEBUG
    always @(posedge clk) begin
        if (!reset) begin
            for (int p = 0; p < NUM_WRITE; p++) begin
                automatic logic won = write_enable[p];
                for (int q = p + 1; q < NUM_WRITE; q++) begin
                    if (write_enable[q] &&
                        write_number[q*ADDR_WIDTH +: ADDR_WIDTH] ==
                        write_number[p*ADDR_WIDTH +: ADDR_WIDTH]) begin
                        won = 1'b0;
                    end
                end
                if (ZERO_REG != 0 && write_number[p*ADDR_WIDTH +: ADDR_WIDTH] == '0) begin
                    won = 1'b0;
                end
                if (won) begin
                    $display("%0t grf write port=%0d index=%0d data=%h", $time, p,
                             write_number[p*ADDR_WIDTH +: ADDR_WIDTH],
                             write_data[p*DATA_WIDTH +: DATA_WIDTH]);
                end
            end
        end
    end
`endif

endmodule
